// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the two-port SDRAM command arbiter.
package sdram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int PORT_ID_W = 1;
    localparam logic [PORT_ID_W-1:0] PORT0 = 1'b0;
    localparam logic [PORT_ID_W-1:0] PORT1 = 1'b1;

    localparam int ADDR_W_DEF   = 23;
    localparam int DATA_W_DEF   = 32;
    localparam int BE_W_DEF     = 4;
    localparam int RD_DEPTH_DEF = 4;

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order FIFO of port IDs, one entry per outstanding read command.
module sdram_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int RD_DEPTH = RD_DEPTH_DEF,
    parameter int CNT_W    = $clog2(RD_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [PORT_ID_W-1:0] push_id,
    input  logic                 pop,
    output logic [PORT_ID_W-1:0] head_id,
    output logic [CNT_W-1:0]     count,
    output logic                 empty,
    output logic                 full
);

    localparam int PTR_W = CNT_W - 1;

    logic [PORT_ID_W-1:0] mem [RD_DEPTH];
    logic [PTR_W-1:0]     wptr;
    logic [PTR_W-1:0]     rptr;

    // Pointers wrap naturally because RD_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < RD_DEPTH; i++) mem[i] <= PORT0;
        end else begin
            if (push) begin
                mem[wptr] <= push_id;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head_id = mem[rptr];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RD_DEPTH));

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin two-port front end for the SDRAM controller command port,
// with read data steered back to the issuing port via an in-order tag FIFO.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BE_W     = BE_W_DEF,
    parameter int RD_DEPTH = RD_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_wr,
    input  logic [BE_W-1:0]   p0_req_be,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_data,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_wr,
    input  logic [BE_W-1:0]   p1_req_be,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_data,
    output logic              p0_rd_valid,
    output logic              p1_rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              cmd_ready,
    output logic              cmd_enable,
    output logic              cmd_wr,
    output logic [BE_W-1:0]   cmd_byte_enable,
    output logic [ADDR_W-1:0] cmd_address,
    output logic [DATA_W-1:0] cmd_data_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic              data_out_ready,
    output logic              rd_orphan
);

    localparam int CNT_W = $clog2(RD_DEPTH) + 1;

    state_t               state, state_next;
    logic [PORT_ID_W-1:0] ptr, winner, grant_id, head_id;
    logic                 grant, accept, elig0, elig1;
    logic                 push, pop, empty, full;
    logic [CNT_W-1:0]     count;
    logic                 unused_count;

    // A port that was just acknowledged is skipped for one cycle so its
    // stale request (still visible while it samples req_ready) is not re-granted.
    // Reads additionally need a free tag slot; writes never return data.
    assign elig0  = p0_req_valid && !p0_req_ready && (p0_req_wr || !full);
    assign elig1  = p1_req_valid && !p1_req_ready && (p1_req_wr || !full);
    assign accept = (state == ISSUE) && cmd_enable && cmd_ready;
    assign push   = accept && !cmd_wr;
    assign pop    = data_out_ready && !empty;

    // count is kept for debug visibility; eligibility uses full/empty.
    assign unused_count = ^count;

    sdram_tag_fifo #(.RD_DEPTH(RD_DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_id (winner),
        .pop     (pop),
        .head_id (head_id),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and grant decision; the pointer only breaks ties.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_id   = PORT0;
        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                    if (elig0 && elig1) grant_id = ptr;
                    else if (elig1)     grant_id = PORT1;
                    else                grant_id = PORT0;
                end
            end
            ISSUE:   if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command registers, request acknowledges and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_enable      <= 1'b0;
            cmd_wr          <= 1'b0;
            cmd_byte_enable <= '0;
            cmd_address     <= '0;
            cmd_data_in     <= '0;
            winner          <= PORT0;
            ptr             <= PORT0;
            p0_req_ready    <= 1'b0;
            p1_req_ready    <= 1'b0;
        end else begin
            p0_req_ready <= 1'b0;
            p1_req_ready <= 1'b0;
            if (grant) begin
                cmd_enable <= 1'b1;
                winner     <= grant_id;
                if (grant_id == PORT1) begin
                    cmd_wr          <= p1_req_wr;
                    cmd_byte_enable <= p1_req_be;
                    cmd_address     <= p1_req_addr;
                    cmd_data_in     <= p1_req_data;
                end else begin
                    cmd_wr          <= p0_req_wr;
                    cmd_byte_enable <= p0_req_be;
                    cmd_address     <= p0_req_addr;
                    cmd_data_in     <= p0_req_data;
                end
            end else if (accept) begin
                cmd_enable   <= 1'b0;
                p0_req_ready <= (winner == PORT0);
                p1_req_ready <= (winner == PORT1);
                ptr          <= ~winner;
            end
        end
    end

    // Read return: register data and pulse the valid of the tagged port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data     <= '0;
            p0_rd_valid <= 1'b0;
            p1_rd_valid <= 1'b0;
            rd_orphan   <= 1'b0;
        end else begin
            p0_rd_valid <= pop && (head_id == PORT0);
            p1_rd_valid <= pop && (head_id == PORT1);
            if (pop) rd_data <= data_out;
            if (data_out_ready && empty) rd_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench: stimulus queues expected commands; monitors compare
// accepted commands, req_ready pulses and read returns as they appear.
module tb_sdram_arbiter;
    localparam int AW = 23;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          p0_req_valid = 0, p0_req_wr = 0, p1_req_valid = 0, p1_req_wr = 0;
    logic [BW-1:0] p0_req_be = 0, p1_req_be = 0;
    logic [AW-1:0] p0_req_addr = 0, p1_req_addr = 0;
    logic [DW-1:0] p0_req_data = 0, p1_req_data = 0;
    logic          p0_req_ready, p1_req_ready, p0_rd_valid, p1_rd_valid, rd_orphan;
    logic [DW-1:0] rd_data, cmd_data_in, data_out;
    logic          cmd_ready = 0, cmd_enable, cmd_wr, data_out_ready;
    logic [BW-1:0] cmd_byte_enable;
    logic [AW-1:0] cmd_address;

    logic          auto_dor = 0, man_dor = 0, auto_ret = 0;
    logic [DW-1:0] auto_data = 0, man_data = 0;
    assign data_out_ready = auto_dor | man_dor;
    assign data_out       = man_dor ? man_data : auto_data;

    sdram_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_wr(p0_req_wr),
        .p0_req_be(p0_req_be), .p0_req_addr(p0_req_addr), .p0_req_data(p0_req_data),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_wr(p1_req_wr),
        .p1_req_be(p1_req_be), .p1_req_addr(p1_req_addr), .p1_req_data(p1_req_data),
        .p0_rd_valid(p0_rd_valid), .p1_rd_valid(p1_rd_valid), .rd_data(rd_data),
        .cmd_ready(cmd_ready), .cmd_enable(cmd_enable), .cmd_wr(cmd_wr),
        .cmd_byte_enable(cmd_byte_enable), .cmd_address(cmd_address), .cmd_data_in(cmd_data_in),
        .data_out(data_out), .data_out_ready(data_out_ready), .rd_orphan(rd_orphan)
    );

    typedef struct packed {
        logic          port;
        logic          wr;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;
    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } rd_t;
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    cmd_t cmd_q[$];
    rd_t  rd_q[$];
    ret_t ret_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic rdy_pend = 0;
    logic rdy_port = 0;

    always @(posedge clk) cyc++;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares every acceptance, ack pulse and read return.
    always @(negedge clk) begin
        cmd_t e;
        rd_t  r;
        ret_t t;
        if (rst) begin
            rdy_pend = 0;
        end else begin
            if (rdy_pend || p0_req_ready || p1_req_ready) begin
                check("req_ready", {62'd0, p1_req_ready, p0_req_ready},
                      !rdy_pend ? 64'd0 : (rdy_port ? 64'd2 : 64'd1));
                rdy_pend = 0;
            end
            if (cmd_enable && cmd_ready) begin
                if (cmd_q.size() == 0) check("cmd_unexpected", 64'd1, 64'd0);
                else begin
                    e = cmd_q.pop_front();
                    check("cmd_fields", {4'd0, cmd_wr, cmd_byte_enable, cmd_address, cmd_data_in},
                          {4'd0, e.wr, e.be, e.addr, e.data});
                    rdy_pend = 1;
                    rdy_port = e.port;
                    if (!e.wr) begin
                        r.port = e.port;
                        r.data = DW'(e.addr);
                        rd_q.push_back(r);
                        if (auto_ret) begin
                            t.due  = cyc + 4;
                            t.data = DW'(e.addr);
                            ret_q.push_back(t);
                        end
                    end
                end
            end
            if (p0_rd_valid || p1_rd_valid) begin
                if (rd_q.size() == 0) check("rd_unexpected", {62'd0, p1_rd_valid, p0_rd_valid}, 64'd0);
                else begin
                    r = rd_q.pop_front();
                    check("rd_return", {30'd0, p1_rd_valid, p0_rd_valid, rd_data},
                          {30'd0, r.port ? 2'b10 : 2'b01, r.data});
                end
            end
        end
    end

    // Controller read-data model: returns data = address 4 cycles after acceptance.
    always @(negedge clk) begin
        auto_dor = 0;
        if (!rst && ret_q.size() > 0 && ret_q[0].due == cyc) begin
            auto_data = ret_q[0].data;
            void'(ret_q.pop_front());
            auto_dor = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int p, input logic wr, input logic [BW-1:0] be,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            p0_req_valid = 1; p0_req_wr = wr; p0_req_be = be; p0_req_addr = a; p0_req_data = d;
        end else begin
            p1_req_valid = 1; p1_req_wr = wr; p1_req_be = be; p1_req_addr = a; p1_req_data = d;
        end
    endtask

    task automatic wait_rdy(input int p, output int n);
        logic done;
        done = 0;
        n    = 0;
        for (int i = 1; i <= 200 && !done; i++) begin
            tick(1);
            if ((p == 0) ? p0_req_ready : p1_req_ready) begin
                done = 1;
                n    = i;
            end
        end
        if (!done) check((p == 0) ? "timeout_p0" : "timeout_p1", 64'd0, 64'd1);
        if (p == 0) p0_req_valid = 0; else p1_req_valid = 0;
    endtask

    task automatic req(input int p, input logic wr, input logic [BW-1:0] be,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        start(p, wr, be, a, d);
        wait_rdy(p, n);
    endtask

    task automatic ret(input logic [DW-1:0] d);
        man_dor  = 1;
        man_data = d;
        tick(1);
        man_dor  = 0;
    endtask

    task automatic push_cmd(input logic p, input logic wr, input logic [BW-1:0] be,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.port = p; c.wr = wr; c.be = be; c.addr = a; c.data = d;
        cmd_q.push_back(c);
    endtask

    task automatic clear_sb();
        cmd_q.delete();
        rd_q.delete();
        ret_q.delete();
    endtask

    task automatic reset_dut();
        rst = 1;
        p0_req_valid = 0; p1_req_valid = 0;
        cmd_ready = 0; man_dor = 0; auto_ret = 0;
        clear_sb();
        tick(2);
        rst = 0;
    endtask

    initial begin
        int n;

        // Reset state and single write
        reset_dut();
        check("rst_cmd", {cmd_enable, cmd_wr, cmd_byte_enable, cmd_address, cmd_data_in}, 64'd0);
        check("rst_misc", {p0_req_ready, p1_req_ready, p0_rd_valid, p1_rd_valid, rd_orphan, rd_data}, 64'd0);
        check("rst_count", 64'(dut.u_fifo.count), 64'd0);
        check("rst_ptr", 64'(dut.ptr), 64'd0);
        cmd_ready = 1;
        push_cmd(0, 1, 4'hF, 23'h000001, 32'h0000AAAA);
        req(0, 1, 4'hF, 23'h000001, 32'h0000AAAA);
        check("wr_enable_drop", 64'(cmd_enable), 64'd0);
        check("wr_count", 64'(dut.u_fifo.count), 64'd0);
        check("wr_ptr_flip", 64'(dut.ptr), 64'd1);

        // Contention: both ports stream reads, grants alternate 0,1,0,1
        reset_dut();
        cmd_ready = 1;
        auto_ret  = 1;
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 0, 4'hF, 23'h000100 + 23'(i), 32'd0);
            push_cmd(1, 0, 4'hF, 23'h000200 + 23'(i), 32'd0);
        end
        fork
            for (int i = 0; i < 4; i++) req(0, 0, 4'hF, 23'h000100 + 23'(i), 32'd0);
            for (int j = 0; j < 4; j++) req(1, 0, 4'hF, 23'h000200 + 23'(j), 32'd0);
        join
        for (int i = 0; i < 50 && rd_q.size() > 0; i++) tick(1);
        check("cont_cmd_drain", 64'(cmd_q.size()), 64'd0);
        check("cont_rd_drain", 64'(rd_q.size()), 64'd0);
        check("cont_count", 64'(dut.u_fifo.count), 64'd0);

        // FIFO full: fifth read waits, write from the other port passes
        reset_dut();
        cmd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            push_cmd(0, 0, 4'hF, 23'h000300 + 23'(i), 32'd0);
            req(0, 0, 4'hF, 23'h000300 + 23'(i), 32'd0);
        end
        check("full_count", 64'(dut.u_fifo.count), 64'd4);
        push_cmd(1, 1, 4'h5, 23'h7FFFFF, 32'hDEADBEEF);
        push_cmd(0, 0, 4'hF, 23'h000304, 32'd0);
        start(0, 0, 4'hF, 23'h000304, 32'd0);
        req(1, 1, 4'h5, 23'h7FFFFF, 32'hDEADBEEF);
        tick(3);
        check("full_blocked", {62'd0, cmd_enable, p0_req_ready}, 64'd0);
        ret(32'h00000300);
        wait_rdy(0, n);
        check("full_count_after", 64'(dut.u_fifo.count), 64'd4);
        for (int i = 1; i <= 4; i++) ret(32'h00000300 + 32'(i));
        tick(2);
        check("full_drain", 64'(dut.u_fifo.count), 64'd0);
        check("full_rd_q", 64'(rd_q.size()), 64'd0);

        // Stall: cmd_ready low while in ISSUE
        reset_dut();
        push_cmd(0, 1, 4'h3, 23'h000400, 32'h12345678);
        start(0, 1, 4'h3, 23'h000400, 32'h12345678);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            check("stall_hold", {3'd0, cmd_enable, cmd_wr, cmd_byte_enable, cmd_address, cmd_data_in},
                  {3'd0, 1'b1, 1'b1, 4'h3, 23'h000400, 32'h12345678});
            tick(1);
        end
        cmd_ready = 1;
        wait_rdy(0, n);
        check("stall_accept_lat", 64'(n), 64'd1);
        check("stall_enable_drop", 64'(cmd_enable), 64'd0);

        // Orphan read data
        reset_dut();
        check("orphan_init", 64'(rd_orphan), 64'd0);
        ret(32'h00000055);
        tick(1);
        check("orphan_set", 64'(rd_orphan), 64'd1);
        tick(5);
        check("orphan_sticky", 64'(rd_orphan), 64'd1);
        check("orphan_count", 64'(dut.u_fifo.count), 64'd0);
        reset_dut();
        check("orphan_clear", 64'(rd_orphan), 64'd0);

        // Reset in ISSUE with two reads outstanding
        cmd_ready = 1;
        push_cmd(0, 0, 4'hF, 23'h000500, 32'd0);
        push_cmd(0, 0, 4'hF, 23'h000501, 32'd0);
        req(0, 0, 4'hF, 23'h000500, 32'd0);
        req(0, 0, 4'hF, 23'h000501, 32'd0);
        check("mid_count", 64'(dut.u_fifo.count), 64'd2);
        cmd_ready = 0;
        start(1, 1, 4'hF, 23'h000600, 32'h00000066);
        tick(2);
        check("mid_issue", 64'(cmd_enable), 64'd1);
        check("mid_ptr_pre", 64'(dut.ptr), 64'd1);
        #2;
        rst = 1;
        #1;
        check("mid_rst_enable", 64'(cmd_enable), 64'd0);
        check("mid_rst_count", 64'(dut.u_fifo.count), 64'd0);
        check("mid_rst_ptr", 64'(dut.ptr), 64'd0);
        clear_sb();
        p1_req_valid = 0;
        tick(1);
        rst = 0;
        ret(32'h00000500);
        tick(1);
        check("mid_late_orphan", 64'(rd_orphan), 64'd1);

        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-port command arbiter in front of the SDRAM controller's command/read port in the clk100 domain.
- Lets two independent requesters share one controller: port 0 is the memory test engine, port 1 is a debug/dump engine.
- Round-robin grants; each accepted command is forwarded as a one-cycle cmd_enable pulse.
- Read returns are steered back to the issuing port by an in-order tag FIFO.

Parameters:
ADDR_W, 23, SDRAM word address width
DATA_W, 32, command/read data width
BE_W, 4, byte-enable width
RD_DEPTH, 4, maximum outstanding reads, power of two

Ports:
clk  in  1  single clock; all logic posedge clk
rst  in  1  asynchronous, active-high reset
p0_req_valid / p1_req_valid  in  1  request pending; fields held stable until the matching req_ready pulse
p0_req_ready / p1_req_ready  out  1  one-cycle pulse: request accepted by the controller
p0_req_wr / p1_req_wr  in  1  1 = write, 0 = read
p0_req_be / p1_req_be  in  BE_W  byte enables
p0_req_addr / p1_req_addr  in  ADDR_W  word address
p0_req_data / p1_req_data  in  DATA_W  write data
p0_rd_valid / p1_rd_valid  out  1  one-cycle pulse: rd_data belongs to this port
rd_data  out  DATA_W  registered read data, shared by both ports
cmd_ready  in  1  controller can accept a command
cmd_enable  out  1  command strobe to controller
cmd_wr  out  1  to controller
cmd_byte_enable  out  BE_W  to controller
cmd_address  out  ADDR_W  to controller
cmd_data_in  out  DATA_W  to controller
data_out  in  DATA_W  controller read data
data_out_ready  in  1  controller read-data-valid pulse
rd_orphan  out  1  sticky: read data arrived with no outstanding tag

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, priority pointer = port 0, tag FIFO empty, rd_orphan 0. Takes effect immediately regardless of state.
- Eligibility:
  - A port is eligible when req_valid=1.
  - A read is also eligible only while tag count < RD_DEPTH.
  - A write is eligible regardless of tag count.
- IDLE:
  - If no port is eligible, stay in IDLE.
  - If one port is eligible, grant it.
  - If both are eligible, grant the port named by the priority pointer.
  - On grant: latch wr/be/addr/data into the cmd_* registers, set cmd_enable=1, record the winner ID, go to ISSUE.
  - Grant-to-cmd_enable latency: 1 cycle, because all outputs are registered.
- ISSUE:
  - Hold cmd_enable and cmd_* stable until a rising edge samples cmd_enable=1 and cmd_ready=1. That edge is acceptance.
  - On acceptance:
    - cmd_enable drops to 0 next cycle.
    - The winner's req_ready pulses for exactly one cycle.
    - If the command was a read, push the winner ID into the tag FIFO.
    - The priority pointer moves to the other port.
    - Return to IDLE.
  - There is no timeout: ISSUE waits indefinitely for cmd_ready.
- Back-to-back commands:
  - A requester samples req_ready, then either drops req_valid or presents its next request.
  - IDLE never re-grants the port whose req_ready is high that same cycle.
  - Minimum spacing between commands is 3 cycles.
- Read return:
  - On data_out_ready=1, pop the head tag.
  - Next cycle: rd_data = data_out, and the tagged port's rd_valid pulses for 1 cycle.
  - Return latency: 1 cycle.
- Simultaneous push and pop in the same cycle: both happen, and the count is unchanged. Push while full is impossible, because reads are gated by the eligibility rule.
- data_out_ready with the FIFO empty: data is dropped, no rd_valid is asserted, and rd_orphan is set to 1. rd_orphan clears only on rst.
- Tag FIFO:
  - Read/write pointers are log2(RD_DEPTH) bits and wrap modulo RD_DEPTH.
  - The count is log2(RD_DEPTH)+1 bits.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1.
- Blocked reads: if the pointed-to port is blocked because its read cannot be tagged, the other port is granted if eligible. The pointer still flips on that grant.

Decomposition:
- Package sdram_arb_pkg holds:
  - the state encoding: IDLE=0, ISSUE=1;
  - PORT_ID_W=1, PORT0=0, PORT1=1;
  - the default widths.
- Sub-module sdram_tag_fifo: a RD_DEPTH x PORT_ID_W synchronous FIFO.
  - Ports: push, push_id, pop, head_id, count, empty, full.
  - Reset is async active-high.

Test Plan:
- Single write: p0 write addr=0x000001, data=0x0000AAAA, be=4'hF, cmd_ready=1 -> cmd_enable high 1 cycle with those fields; p0_req_ready pulses once; tag count stays 0.
- Contention: p0 and p1 continuously request reads, and the model returns data_out_ready 4 cycles after each acceptance with data_out = address -> acceptances alternate p0,p1,p0,p1; each rd_valid lands on the correct port with rd_data equal to that port's address.
- FIFO full: p0 issues 4 reads with no data_out_ready returned -> 5th p0 read not granted; a p1 write is still granted; after one return, the 5th read is granted.
- Stall: cmd_ready held 0 for 10 cycles while in ISSUE -> cmd_enable and cmd_* stay stable; acceptance occurs on the first cycle cmd_ready=1.
- Orphan: data_out_ready pulse with the FIFO empty -> no rd_valid; rd_orphan=1 and sticky until rst.
- Reset mid-operation: assert rst during ISSUE with 2 reads outstanding -> cmd_enable=0 immediately, count=0, pointer=0; late data_out_ready after reset sets rd_orphan.
